// File: rtl/fir_mac.sv
// fir_mac: sweeps TAPS sample/coefficient pairs from upstream memories, accumulates
// their products and emits one rounded, saturated 16-bit result per start.
module fir_mac #(
  parameter int TAPS  = 32,
  parameter int AW    = $clog2(TAPS),
  parameter int ACC_W = 32 + $clog2(TAPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  output logic [AW-1:0]        adres,
  output logic [AW-1:0]        coef_adr,
  input  logic signed [15:0]   probka,
  input  logic signed [15:0]   wsp,
  output logic signed [15:0]   y_out,
  output logic                 y_valid,
  output logic                 busy,
  output logic                 overrun
);
  typedef enum logic [2:0] {IDLE, RUN, FLUSH, DONE, OUT} state_t;
  state_t                   state_q;
  logic [AW-1:0]            adres_q;
  logic                     vld_q, y_valid_q, busy_q, overrun_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d, rnd;
  logic signed [31:0]       prod;
  logic signed [15:0]       y_q, y_d;
  always_comb begin
    prod  = 32'(probka) * 32'(wsp);
    acc_d = acc_q + {{(ACC_W-32){prod[31]}}, prod};
    rnd   = (acc_q + ACC_W'(16384)) >>> 15;
    y_d   = (rnd > ACC_W'(32767)) ? 16'sh7fff : (rnd < ACC_W'(-32768)) ? 16'sh8000 : rnd[15:0];
  end
  // read data arrives one cycle after its address, so vld_q trails RUN by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      adres_q   <= '0;
      vld_q     <= 1'b0;
      acc_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (abort) begin
      state_q   <= IDLE;
      adres_q   <= '0;
      vld_q     <= 1'b0;
      acc_q     <= '0;
      y_valid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      overrun_q <= overrun_q | (start && state_q != IDLE);
      vld_q     <= state_q == RUN;
      if (vld_q) acc_q <= acc_d;
      case (state_q)
        IDLE: begin
          acc_q <= '0;
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          adres_q <= (adres_q == AW'(TAPS-1)) ? '0 : adres_q + AW'(1);
          if (adres_q == AW'(TAPS-1)) state_q <= FLUSH;
        end
        FLUSH: state_q <= DONE;
        DONE: begin
          y_q       <= y_d;
          y_valid_q <= 1'b1;
          state_q   <= OUT;
        end
        OUT: begin
          y_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign adres    = adres_q;
  assign coef_adr = adres_q;
  assign y_out    = y_q;
  assign y_valid  = y_valid_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;
endmodule

// File: tb/tb_fir_mac.sv
// tb_fir_mac: scenario tasks plus a scoreboard of model results popped on each y_valid.
module tb_fir_mac;
  localparam int TAPS = 32;
  logic clk = 0, rst_n = 0, start = 0, abort = 0;
  logic [4:0] adres, coef_adr;
  logic signed [15:0] probka = 0, wsp = 0, y_out;
  logic y_valid, busy, overrun;
  logic signed [15:0] samp [TAPS];
  logic signed [15:0] coef [TAPS];
  logic signed [15:0] sb [$];
  logic signed [15:0] last_exp = 0, exp_y;
  int n_checks = 0, n_fail = 0;

  fir_mac dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .adres(adres), .coef_adr(coef_adr), .probka(probka), .wsp(wsp),
    .y_out(y_out), .y_valid(y_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // upstream shift register and coefficient memory, both with 1-cycle read latency
  always @(posedge clk) begin
    probka <= samp[adres];
    wsp    <= coef[coef_adr];
  end

  function automatic logic signed [15:0] model();
    longint acc = 0, r;
    for (int i = 0; i < TAPS; i++) acc += longint'(samp[i]) * longint'(coef[i]);
    r = (acc + 16384) >>> 15;
    return (r > 32767) ? 16'sh7fff : (r < -32768) ? 16'sh8000 : 16'(r);
  endfunction

  always @(negedge clk) begin
    if (rst_n && y_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: unexpected y_valid, y_out=%0d, expected none", y_out);
      end else begin
        exp_y = sb.pop_front();
        if (y_out !== exp_y) begin
          n_fail++;
          $display("FAIL scoreboard: y_out=%0d expected %0d", y_out, exp_y);
        end
      end
    end
  end

  task automatic go(input bit push);
    @(negedge clk);
    start = 1;
    if (push) begin
      last_exp = model();
      sb.push_back(last_exp);
    end
    @(negedge clk);
    start = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fill_random();
    for (int i = 0; i < TAPS; i++) begin
      samp[i] = 16'($urandom_range(0, 65535));
      coef[i] = 16'($urandom_range(0, 65535));
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({y_out, y_valid, busy, overrun, adres, coef_adr} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got y=%0d v=%b b=%b o=%b a=%0d c=%0d expected all 0", y_out, y_valid, busy, overrun, adres, coef_adr);
    end
    fill_random();
    go(1);
    step(10);
    n_checks++;
    if (adres !== 5'd10) begin n_fail++; $display("FAIL reset_pre_addr: adres=%0d expected 10", adres); end
    rst_n = 0;
    #1;
    n_checks++;
    if ({y_out, y_valid, busy, overrun, adres, coef_adr} !== '0) begin
      n_fail++;
      $display("FAIL reset_midrun: got y=%0d v=%b b=%b o=%b a=%0d c=%0d expected all 0", y_out, y_valid, busy, overrun, adres, coef_adr);
    end
    sb.delete();
    last_exp = 0;
    @(negedge clk);
    rst_n = 1;
    go(1);
    step(34);
    n_checks++;
    if (y_valid !== 1'b1) begin n_fail++; $display("FAIL reset_rerun_valid: y_valid=%b expected 1 at cycle 35", y_valid); end
    step(1);
    n_checks++;
    if (busy !== 1'b0 || y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rerun_idle: busy=%b y_valid=%b expected 0 0", busy, y_valid); end
  endtask

  task automatic test_single_tap();
    for (int i = 0; i < TAPS; i++) begin
      samp[i] = 16'($urandom_range(1, 32767));
      coef[i] = 0;
    end
    samp[0] = 16'sd1000;
    coef[0] = 16'sh4000;
    go(1);
    for (int k = 1; k <= TAPS; k++) begin
      n_checks++;
      if (adres !== 5'(k-1) || coef_adr !== 5'(k-1) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_addr: cycle %0d adres=%0d coef_adr=%0d busy=%b expected %0d %0d 1", k, adres, coef_adr, busy, k-1, k-1);
      end
      step(1);
    end
    for (int k = 33; k <= 34; k++) begin
      n_checks++;
      if (y_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL single_early: cycle %0d y_valid=%b busy=%b expected 0 1", k, y_valid, busy); end
      step(1);
    end
    n_checks++;
    if (y_valid !== 1'b1 || y_out !== 16'sd500) begin n_fail++; $display("FAIL single_result: y_valid=%b y_out=%0d expected 1 500", y_valid, y_out); end
    step(1);
    n_checks++;
    if (y_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after: y_valid=%b busy=%b expected 0 0", y_valid, busy); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < TAPS; i++) begin
      samp[i] = 16'sd3200;
      coef[i] = 16'sh0400;
    end
    go(1);
    step(34);
    n_checks++;
    if (y_valid !== 1'b1 || y_out !== 16'sd3200) begin n_fail++; $display("FAIL full_sum: y_valid=%b y_out=%0d expected 1 3200", y_valid, y_out); end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || y_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle36: busy=%b y_valid=%b expected 0 0", busy, y_valid); end
    start = 1;
    last_exp = model();
    sb.push_back(last_exp);
    @(negedge clk);
    start = 0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy=%b expected 1", busy); end
    step(34);
    n_checks++;
    if (y_valid !== 1'b1 || y_out !== 16'sd3200) begin n_fail++; $display("FAIL b2b_cycle71: y_valid=%b y_out=%0d expected 1 3200", y_valid, y_out); end
    step(1);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < TAPS; i++) begin
      samp[i] = 16'sh7fff;
      coef[i] = 16'sh7fff;
    end
    go(1);
    step(35);
    n_checks++;
    if (y_out !== 16'sh7fff) begin n_fail++; $display("FAIL sat_pos: y_out=%0d expected 32767", y_out); end
    for (int i = 0; i < TAPS; i++) samp[i] = 16'sh8000;
    go(1);
    step(35);
    n_checks++;
    if (y_out !== 16'sh8000) begin n_fail++; $display("FAIL sat_neg: y_out=%0d expected -32768", y_out); end
  endtask

  task automatic test_rounding();
    logic signed [15:0] pin [3];
    logic signed [15:0] pexp [3];
    pin  = '{16'sh3fff, 16'sh4000, 16'shc000};
    pexp = '{16'sd0, 16'sd1, 16'sd0};
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < TAPS; i++) begin
        samp[i] = 16'($urandom_range(0, 65535));
        coef[i] = 0;
      end
      coef[0] = 16'sh0001;
      samp[0] = pin[t];
      go(1);
      step(35);
      n_checks++;
      if (y_out !== pexp[t]) begin n_fail++; $display("FAIL round_%0d: probka0=%h y_out=%0d expected %0d", t, pin[t], y_out, pexp[t]); end
    end
  endtask

  task automatic test_overrun();
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL overrun_clear: overrun=%b expected 0", overrun); end
    fill_random();
    go(1);
    step(4);
    start = 1;
    @(negedge clk);
    start = 0;
    n_checks++;
    if (overrun !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL overrun_set: overrun=%b busy=%b expected 1 1", overrun, busy); end
    step(29);
    n_checks++;
    if (y_valid !== 1'b1) begin n_fail++; $display("FAIL overrun_result: y_valid=%b expected 1 at cycle 35", y_valid); end
    step(1);
  endtask

  task automatic test_abort();
    bit seen = 0;
    fill_random();
    go(0);
    step(19);
    abort = 1;
    @(negedge clk);
    abort = 0;
    n_checks++;
    if (busy !== 1'b0 || adres !== 5'd0) begin n_fail++; $display("FAIL abort_idle: busy=%b adres=%0d expected 0 0", busy, adres); end
    for (int k = 0; k < 40; k++) begin
      seen |= y_valid;
      step(1);
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL abort_no_valid: y_valid seen=1 expected 0"); end
    n_checks++;
    if (y_out !== last_exp) begin n_fail++; $display("FAIL abort_hold: y_out=%0d expected %0d", y_out, last_exp); end
    abort = 1;
    start = 1;
    @(negedge clk);
    abort = 0;
    start = 0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_start: busy=%b expected 0", busy); end
    fill_random();
    go(1);
    step(35);
    n_checks++;
    if (y_out !== last_exp) begin n_fail++; $display("FAIL abort_rerun: y_out=%0d expected %0d", y_out, last_exp); end
  endtask

  initial begin
    for (int i = 0; i < TAPS; i++) begin
      samp[i] = 0;
      coef[i] = 0;
    end
    step(3);
    rst_n = 1;
    step(1);
    test_reset();
    test_single_tap();
    test_back_to_back();
    test_saturation();
    test_rounding();
    test_overrun();
    test_abort();
    step(2);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d results pending expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
